dlk_buffer_ctrl: RTL

- Sequencer and arbiter in front of the base-address circular buffer used for data-leak and overflow detection.
- Serialises three kinds of work onto the buffer's single interface:
  - base-address registrations from NUM_REG requesters, arbitrated round-robin;
  - overflow checks from the load/store path;
  - buffer clears.
- Returns check results over a valid/ready response channel.
- Keeps a sticky alarm flag and a saturating overflow counter for CSR/debug readout.

---
 rtl/dlk_pkg.sv | 21 ++
 rtl/dlk_rr_arbiter.sv | 39 +++
 rtl/dlk_buffer_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dlk_pkg.sv
// rtl/dlk_pkg.sv - shared types and constants for the base-address buffer controller
//
// Purpose: FSM state encoding, default address width and the buffer's
// empty-slot marker, shared by the controller and the buffer itself.
// Ports: none (package).
package dlk_pkg;

  localparam int XLEN_DLK = 32;

  // A base address of zero marks an empty buffer slot, so it can never be registered.
  localparam logic [XLEN_DLK-1:0] DLK_EMPTY_ADDR = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_CHECK = 3'd2,
    ST_RESP  = 3'd3,
    ST_CLEAR = 3'd4
  } dlk_ctrl_state_e;

endpackage

// File: rtl/dlk_rr_arbiter.sv
// rtl/dlk_rr_arbiter.sv - combinational round-robin arbiter for registration requesters
//
// Purpose: grants the first requesting index at or after ptr_i, wrapping.
// Ports:
//   req_i     [NUM_REG]  request vector
//   ptr_i     [PTR_W]    search start index
//   en_i                 grant allowed this cycle
//   gnt_o     [NUM_REG]  one-hot grant (all zero when disabled or idle)
//   gnt_idx_o [PTR_W]    index of the granted requester
module dlk_rr_arbiter #(
  parameter int NUM_REG = 2,
  parameter int PTR_W   = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
  input  logic [NUM_REG-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REG-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o
);

  logic             w_found;
  logic [PTR_W-1:0] w_j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_j       = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      w_j = PTR_W'((int'(ptr_i) + i) % NUM_REG);
      if (en_i && !w_found && req_i[w_j]) begin
        w_found   = 1'b1;
        gnt_o[w_j] = 1'b1;
        gnt_idx_o = w_j;
      end
    end
  end

endmodule

// File: rtl/dlk_buffer_ctrl.sv
// rtl/dlk_buffer_ctrl.sv - sequencer/arbiter in front of the base-address circular buffer
//
// Purpose: serialises registrations (round-robin), overflow checks and clears
// onto the buffer's single interface; returns check results; keeps a sticky
// alarm and a saturating overflow counter.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   reg_valid_i/reg_addr_i/reg_ready_o  registration requests, one-hot accept
//   chk_valid_i/chk_base_i/chk_addr_i/chk_ready_o  check requests
//   rsp_valid_o/rsp_overflow_o/rsp_ready_i         check results
//   clear_i/clear_ack_o                 flush request / one-cycle ack
//   buf_*                               buffer-side interface
//   alarm_o, ovf_count_o                status readout
module dlk_buffer_ctrl
  import dlk_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_REG    = 2,
  parameter int CNT_W      = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REG-1:0]      reg_valid_i,
  input  logic [NUM_REG*XLEN-1:0] reg_addr_i,
  output logic [NUM_REG-1:0]      reg_ready_o,
  input  logic                    chk_valid_i,
  input  logic [XLEN-1:0]         chk_base_i,
  input  logic [XLEN-1:0]         chk_addr_i,
  output logic                    chk_ready_o,
  output logic                    rsp_valid_o,
  output logic                    rsp_overflow_o,
  input  logic                    rsp_ready_i,
  input  logic                    clear_i,
  output logic                    clear_ack_o,
  output logic                    buf_en_write_o,
  output logic [XLEN-1:0]         buf_base_addr_o,
  output logic [XLEN-1:0]         buf_read_addr_o,
  output logic                    buf_clear_o,
  input  logic                    buf_overflow_i,
  output logic                    alarm_o,
  output logic [CNT_W-1:0]        ovf_count_o
);

  localparam int PTR_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  dlk_ctrl_state_e   r_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [STV_W-1:0]  r_starve_cnt;
  logic [XLEN-1:0]   r_base;
  logic [XLEN-1:0]   r_addr;
  logic              r_en_write;
  logic              r_ovf_q;
  logic              r_alarm;
  logic [CNT_W-1:0]  r_ovf_cnt;

  logic              w_idle;
  logic              w_any_reg;
  logic              w_starved;
  logic              w_take_chk;
  logic              w_take_reg;
  logic [NUM_REG-1:0] w_gnt;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [XLEN-1:0]   w_reg_addr;
  logic [PTR_W-1:0]  w_next_ptr;

  // Accepts are gated by reset so no handshake fires while the block is held in reset.
  assign w_idle     = (r_state == ST_IDLE) && !rst_i;
  assign w_any_reg  = |reg_valid_i;
  // A pending registration blocks further checks once STARVE_MAX checks have gone ahead of it.
  assign w_starved  = w_any_reg && (r_starve_cnt == STV_W'(STARVE_MAX));
  assign w_take_chk = w_idle && !clear_i && chk_valid_i && !w_starved;
  assign w_take_reg = w_idle && !clear_i && !w_take_chk && w_any_reg;

  dlk_rr_arbiter #(
    .NUM_REG (NUM_REG),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i     (reg_valid_i),
    .ptr_i     (r_rr_ptr),
    .en_i      (w_take_reg),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  assign w_reg_addr = reg_addr_i[int'(w_gnt_idx)*XLEN +: XLEN];
  assign w_next_ptr = (w_gnt_idx == PTR_W'(NUM_REG - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

  assign reg_ready_o     = w_gnt;
  assign chk_ready_o     = w_take_chk;
  assign rsp_valid_o     = (r_state == ST_RESP);
  assign rsp_overflow_o  = r_ovf_q;
  assign clear_ack_o     = (r_state == ST_CLEAR);
  assign buf_clear_o     = rst_i || (r_state == ST_CLEAR);
  assign buf_en_write_o  = r_en_write;
  assign buf_base_addr_o = r_base;
  assign buf_read_addr_o = r_addr;
  assign alarm_o         = r_alarm;
  assign ovf_count_o     = r_ovf_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_starve_cnt <= '0;
      r_base       <= '0;
      r_addr       <= '0;
      r_en_write   <= 1'b0;
      r_ovf_q      <= 1'b0;
      r_alarm      <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      r_en_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear_i) begin
            r_state <= ST_CLEAR;
          end else if (w_take_chk) begin
            r_base       <= chk_base_i;
            r_addr       <= chk_addr_i;
            r_starve_cnt <= w_any_reg ? r_starve_cnt + STV_W'(1) : '0;
            r_state      <= ST_CHECK;
          end else if (w_take_reg) begin
            r_base       <= w_reg_addr;
            r_starve_cnt <= '0;
            r_rr_ptr     <= w_next_ptr;
            // The empty marker cannot be stored, so it is acknowledged and dropped.
            if (w_reg_addr != XLEN'(DLK_EMPTY_ADDR)) begin
              r_en_write <= 1'b1;
              r_state    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
        end
        ST_CHECK: begin
          r_ovf_q <= buf_overflow_i;
          if (buf_overflow_i) begin
            r_alarm <= 1'b1;
            if (r_ovf_cnt != '1) begin
              r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          r_alarm      <= 1'b0;
          r_ovf_cnt    <= '0;
          r_rr_ptr     <= '0;
          r_starve_cnt <= '0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
